// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// States, forwarding codes and default widths.
package pipe_ctrl_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LD_STALL = 2'b01,
        BR_FLUSH = 2'b10
    } state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

endpackage

// File: rtl/pipe_fwd_unit.sv
// Operand forwarding compare for one EX source register.
// Youngest producer (EX/MEM) wins over MEM/WB; r0 never forwards.
module pipe_fwd_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    output logic [1:0]        fwd
);

    // Priority select of the forwarding source
    always_comb begin
        fwd = FWD_RF;
        if (ex_regwrite && ex_rd != '0 && ex_rd == src)
            fwd = FWD_EXMEM;
        else if (mem_regwrite && mem_rd != '0 && mem_rd == src)
            fwd = FWD_MEMWB;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline.
// Load-use stalls, taken-branch flushes and registered forwarding selects.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEF,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic              ex_branch,
    input  logic              ex_zero,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              flush_ifid,
    output logic              bubble_idex,
    output logic              pc_sel_branch,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int CMAX = (LOAD_LAT > FLUSH_CYCLES) ? LOAD_LAT : FLUSH_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX + 1) : 1;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          br_taken, lu_haz;
    logic          stall_inc, flush_inc;
    logic [1:0]    fa_c, fb_c;

    assign br_taken = ex_valid & ex_branch & ex_zero;
    assign lu_haz   = id_valid & ex_valid & ex_memread & ex_regwrite
                    & (ex_rd != '0)
                    & ((id_use_rs & (id_rs == ex_rd))
                     | (id_use_rt & (id_rt == ex_rd)));

    pipe_fwd_unit #(.REG_AW(REG_AW)) u_fwd_rs (
        .src          (id_rs),
        .ex_rd        (ex_rd),
        .ex_regwrite  (ex_regwrite),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .fwd          (fa_c)
    );

    pipe_fwd_unit #(.REG_AW(REG_AW)) u_fwd_rt (
        .src          (id_rt),
        .ex_rd        (ex_rd),
        .ex_regwrite  (ex_regwrite),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .fwd          (fb_c)
    );

    // Next state and hazard controls; all quiet while in reset
    always_comb begin
        state_n       = state_q;
        cnt_n         = cnt_q;
        stall_pc      = 1'b0;
        stall_ifid    = 1'b0;
        flush_ifid    = 1'b0;
        bubble_idex   = 1'b0;
        pc_sel_branch = 1'b0;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                RUN, LD_STALL: begin
                    if (br_taken) begin
                        pc_sel_branch = 1'b1;
                        flush_ifid    = 1'b1;
                        bubble_idex   = 1'b1;
                        flush_inc     = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_n = BR_FLUSH;
                            cnt_n   = CW'(FLUSH_CYCLES - 1);
                        end else begin
                            state_n = RUN;
                        end
                    end else if (state_q == LD_STALL || lu_haz) begin
                        stall_pc    = 1'b1;
                        stall_ifid  = 1'b1;
                        bubble_idex = 1'b1;
                        stall_inc   = 1'b1;
                        if (state_q == LD_STALL) begin
                            cnt_n = cnt_q - CW'(1);
                            if (cnt_q == CW'(1))
                                state_n = RUN;
                        end else if (LOAD_LAT > 1) begin
                            state_n = LD_STALL;
                            cnt_n   = CW'(LOAD_LAT - 1);
                        end
                    end
                end
                BR_FLUSH: begin
                    flush_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                    cnt_n       = cnt_q - CW'(1);
                    if (cnt_q == CW'(1))
                        state_n = RUN;
                end
                default: state_n = RUN;
            endcase
        end
    end

    // State, sequence counter, event counters and forwarding registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            fwd_a     <= FWD_RF;
            fwd_b     <= FWD_RF;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            fwd_a   <= bubble_idex ? FWD_RF : fa_c;
            fwd_b   <= bubble_idex ? FWD_RF : fb_c;
            if (stall_inc && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl.
// Two instances (1/1 and 2/2 latencies) against a sequence-level model.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_use_rs, id_use_rt;
    logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
    logic       ex_valid, ex_regwrite, ex_memread, ex_branch, ex_zero;
    logic       mem_regwrite;

    logic        spc [2];
    logic        sif [2];
    logic        fif [2];
    logic        bub [2];
    logic        pcs [2];
    logic [1:0]  fa  [2];
    logic [1:0]  fb  [2];
    logic [1:0]  st  [2];
    logic [15:0] sc  [2];
    logic [15:0] fc  [2];

    int cmp   = 0;
    int fails = 0;

    // model: kind 0 none, 1 load stall, 2 branch flush
    int         LL [2] = '{1, 2};
    int         FC [2] = '{1, 2};
    int         mk  [2];
    int         mrem[2];
    int         ms  [2];
    int         mf  [2];
    logic [1:0] mfa [2];
    logic [1:0] mfb [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pipe_hazard_ctrl #(
            .REG_AW(5), .LOAD_LAT(g + 1), .FLUSH_CYCLES(g + 1), .CNT_W(16)
        ) dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .id_valid      (id_valid),
            .id_rs         (id_rs),
            .id_rt         (id_rt),
            .id_use_rs     (id_use_rs),
            .id_use_rt     (id_use_rt),
            .ex_valid      (ex_valid),
            .ex_rd         (ex_rd),
            .ex_regwrite   (ex_regwrite),
            .ex_memread    (ex_memread),
            .ex_branch     (ex_branch),
            .ex_zero       (ex_zero),
            .mem_rd        (mem_rd),
            .mem_regwrite  (mem_regwrite),
            .stall_pc      (spc[g]),
            .stall_ifid    (sif[g]),
            .flush_ifid    (fif[g]),
            .bubble_idex   (bub[g]),
            .pc_sel_branch (pcs[g]),
            .fwd_a         (fa[g]),
            .fwd_b         (fb[g]),
            .state         (st[g]),
            .stall_cnt     (sc[g]),
            .flush_cnt     (fc[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        cmp++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] src_fwd(input logic [4:0] s);
        if (ex_regwrite && ex_rd != 0 && ex_rd == s) return 2'b01;
        if (mem_regwrite && mem_rd != 0 && mem_rd == s) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mk[i] = 0; mrem[i] = 0; ms[i] = 0; mf[i] = 0;
            mfa[i] = 2'b00; mfb[i] = 2'b00;
        end
    endtask

    task automatic clear_in();
        id_valid = 0; id_use_rs = 0; id_use_rt = 0;
        id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0;
        ex_valid = 0; ex_regwrite = 0; ex_memread = 0;
        ex_branch = 0; ex_zero = 0; mem_regwrite = 0;
    endtask

    task automatic rand_in();
        id_valid     = ($urandom_range(0, 3) != 0);
        id_use_rs    = $urandom_range(0, 1);
        id_use_rt    = $urandom_range(0, 1);
        id_rs        = 5'($urandom_range(0, 3));
        id_rt        = 5'($urandom_range(0, 3));
        ex_rd        = 5'($urandom_range(0, 3));
        mem_rd       = 5'($urandom_range(0, 3));
        ex_valid     = ($urandom_range(0, 3) != 0);
        ex_regwrite  = $urandom_range(0, 1);
        ex_memread   = $urandom_range(0, 1);
        ex_branch    = ($urandom_range(0, 4) == 0);
        ex_zero      = $urandom_range(0, 1);
        mem_regwrite = $urandom_range(0, 1);
    endtask

    // one clock: check combinational response, advance model, check registers
    task automatic step();
        logic br, lu;
        logic [4:0] e;
        #2;
        br = ex_valid && ex_branch && ex_zero;
        lu = id_valid && ex_valid && ex_memread && ex_regwrite && ex_rd != 0
             && ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
        for (int i = 0; i < 2; i++) begin
            // e = {stall_pc, stall_ifid, flush_ifid, bubble_idex, pc_sel}
            e = 5'b0;
            if (mk[i] == 2) begin
                e = 5'b00110;
                mrem[i]--;
                if (mrem[i] == 0) mk[i] = 0;
            end else if (br) begin
                e = 5'b00111;
                mf[i] = sat(mf[i]);
                mrem[i] = FC[i] - 1;
                mk[i] = (mrem[i] > 0) ? 2 : 0;
            end else if (mk[i] == 1 || lu) begin
                e = 5'b11010;
                ms[i] = sat(ms[i]);
                if (mk[i] == 1) begin
                    mrem[i]--;
                    if (mrem[i] == 0) mk[i] = 0;
                end else begin
                    mrem[i] = LL[i] - 1;
                    mk[i] = (mrem[i] > 0) ? 1 : 0;
                end
            end
            mfa[i] = e[1] ? 2'b00 : src_fwd(id_rs);
            mfb[i] = e[1] ? 2'b00 : src_fwd(id_rt);
            check(i == 0 ? "comb_u0" : "comb_u1",
                  64'({spc[i], sif[i], fif[i], bub[i], pcs[i]}), 64'(e));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            check(i == 0 ? "regs_u0" : "regs_u1",
                  64'({st[i], fa[i], fb[i], sc[i], fc[i]}),
                  64'({2'(mk[i]), mfa[i], mfb[i], 16'(ms[i]), 16'(mf[i])}));
    endtask

    initial begin
        clear_in();
        rst_n = 0;
        model_reset();

        // reset held with toggling inputs: everything quiet
        for (int k = 0; k < 4; k++) begin
            rand_in();
            ex_branch = 1; ex_zero = 1; ex_valid = 1;
            #3;
            for (int i = 0; i < 2; i++)
                check("reset_all", 64'({spc[i], sif[i], fif[i], bub[i], pcs[i],
                      st[i], fa[i], fb[i], sc[i], fc[i]}), 64'(0));
            @(posedge clk);
            #1;
        end
        clear_in();
        rst_n = 1;

        // load-use on rs=8
        id_valid = 1; id_use_rs = 1; id_rs = 8;
        ex_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 8;
        step();
        clear_in();
        step();
        step();
        check("lu_cnt_u0", 64'(sc[0]), 64'd1);
        check("lu_cnt_u1", 64'(sc[1]), 64'd2);

        // ex_rd = 0 never stalls
        id_valid = 1; id_use_rs = 1; id_rs = 0;
        ex_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 0;
        step();
        clear_in();
        step();
        check("rd0_cnt_u1", 64'(sc[1]), 64'd2);

        // branch concurrent with load-use: branch wins
        id_valid = 1; id_use_rt = 1; id_rt = 3;
        ex_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 3;
        ex_branch = 1; ex_zero = 1;
        step();
        clear_in();
        step();
        step();
        check("br_fcnt_u1", 64'(fc[1]), 64'd1);
        check("br_scnt_u1", 64'(sc[1]), 64'd2);

        // forwarding: EX over MEM, MEM only, bubble forces RF
        id_valid = 1; id_rt = 5; ex_valid = 1;
        ex_rd = 5; ex_regwrite = 1; mem_rd = 5; mem_regwrite = 1;
        step();
        check("fwd_ex", 64'(fb[0]), 64'd1);
        ex_regwrite = 0;
        step();
        check("fwd_mem", 64'(fb[0]), 64'd2);
        ex_regwrite = 1; ex_memread = 1; id_use_rt = 1;
        step();
        check("fwd_bub", 64'(fb[0]), 64'd0);
        clear_in();
        step();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rand_in();
            step();
        end
        clear_in();
        step();
        step();

        // reset in the middle of a branch flush
        ex_valid = 1; ex_branch = 1; ex_zero = 1;
        step();
        clear_in();
        check("midflush_st", 64'(st[1]), 64'd2);
        #3;
        rst_n = 0;
        #1;
        check("midflush_rst", 64'({fif[1], bub[1], pcs[1], st[1], sc[1], fc[1]}),
              64'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;

        // saturate the stall counter
        id_valid = 1; id_use_rs = 1; id_rs = 8;
        ex_valid = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 8;
        for (int n = 0; n < 65540; n++) step();
        check("sat_u0", 64'(sc[0]), 64'hFFFF);
        check("sat_u1", 64'(sc[1]), 64'hFFFF);
        clear_in();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
        $finish;
    end

endmodule
